// File: rtl/uart_imem_loader.sv
// Loads the instruction memory with little-endian 32-bit words received over UART and holds the core in reset until the load finishes.
// Optional macro LOADER_BYTE_TIMEOUT_EN: drops a partially assembled word after TIMEOUT_CYCLES idle cycles.
module uart_imem_loader #(
    parameter int unsigned ADDR_W         = 8,
    parameter int unsigned TIMEOUT_CYCLES = 200000
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              uart_rx_valid,
    input  logic [7:0]        uart_rx_data,
    input  logic              uart_rx_break,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              write_done,
    output logic              overflow,
    output logic              cpu_resetn,
    output logic [ADDR_W:0]   word_count
);

    localparam int unsigned CNT_W = ADDR_W + 1;

    typedef enum logic [1:0] {LOAD, WRITE, DONE} state_t;

    state_t            state;
    logic              armed;
    logic [1:0]        byte_idx;
    logic [31:0]       word;
    logic [ADDR_W-1:0] addr;
    logic              accept_c;
    logic [31:0]       word_next_c;

`ifdef LOADER_BYTE_TIMEOUT_EN
    localparam int unsigned TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    logic [TO_W-1:0] to_cnt;
`endif

    // armed keeps the first post-reset edge from accepting a byte
    assign accept_c   = armed & uart_rx_valid & ~uart_rx_break & ~write_done;
    assign cpu_resetn = write_done;

    always_comb begin
        word_next_c = word;
        case (byte_idx)
            2'd0:    word_next_c[7:0]   = uart_rx_data;
            2'd1:    word_next_c[15:8]  = uart_rx_data;
            2'd2:    word_next_c[23:16] = uart_rx_data;
            default: word_next_c[31:24] = uart_rx_data;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= LOAD;
            armed      <= 1'b0;
            byte_idx   <= 2'd0;
            word       <= 32'd0;
            addr       <= '0;
            word_count <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= 32'd0;
            write_done <= 1'b0;
            overflow   <= 1'b0;
`ifdef LOADER_BYTE_TIMEOUT_EN
            to_cnt     <= '0;
`endif
        end else begin
            armed   <= 1'b1;
            imem_we <= 1'b0;
            case (state)
                LOAD: begin
                    if (uart_rx_break) begin
                        byte_idx <= 2'd0;
                        word     <= 32'd0;
`ifdef LOADER_BYTE_TIMEOUT_EN
                        to_cnt   <= '0;
`endif
                    end else if (accept_c) begin
`ifdef LOADER_BYTE_TIMEOUT_EN
                        to_cnt <= '0;
`endif
                        if (byte_idx == 2'd3) begin
                            byte_idx <= 2'd0;
                            word     <= 32'd0;
                            if (word_next_c == 32'hFFFF_FFFF) begin
                                state      <= DONE;
                                write_done <= 1'b1;
                            end else begin
                                state      <= WRITE;
                                imem_we    <= 1'b1;
                                imem_addr  <= addr;
                                imem_wdata <= word_next_c;
                            end
                        end else begin
                            byte_idx <= byte_idx + 2'd1;
                            word     <= word_next_c;
                        end
                    end
`ifdef LOADER_BYTE_TIMEOUT_EN
                    else if (byte_idx != 2'd0) begin
                        if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                            byte_idx <= 2'd0;
                            word     <= 32'd0;
                            to_cnt   <= '0;
                        end else begin
                            to_cnt <= to_cnt + TO_W'(1);
                        end
                    end
`endif
                end
                WRITE: begin
                    word_count <= word_count + CNT_W'(1);
                    if (addr == {ADDR_W{1'b1}}) begin
                        state      <= DONE;
                        write_done <= 1'b1;
                        overflow   <= 1'b1;
                    end else begin
                        addr  <= addr + ADDR_W'(1);
                        state <= LOAD;
                    end
                    // a byte landing during the write starts the next word
                    if (accept_c) begin
                        word     <= word_next_c;
                        byte_idx <= 2'd1;
                    end
                end
                default: begin
                    state <= DONE;
                end
            endcase
        end
    end

endmodule

// File: doc/uart_imem_loader.md
UART_IMEM_LOADER -- requirements
Module: uart_imem_loader

Interface
REQ-001 Parameter ADDR_W, default 8, word-address width of instruction memory (depth 2^ADDR_W words).
REQ-002 Parameter TIMEOUT_CYCLES, default 200000, inter-byte timeout in clk cycles (used only when LOADER_BYTE_TIMEOUT_EN is defined).
REQ-003 Port clk  input  1  system clock, all state on rising edge.
REQ-004 Port resetn  input  1  asynchronous active-low reset.
REQ-005 Port uart_rx_valid  input  1  one-cycle pulse per received UART byte.
REQ-006 Port uart_rx_data  input  8  received byte, qualified by uart_rx_valid.
REQ-007 Port uart_rx_break  input  1  BREAK detected on UART line.
REQ-008 Port imem_we  output  1  one-cycle instruction memory write strobe.
REQ-009 Port imem_addr  output  ADDR_W  word address for imem_we.
REQ-010 Port imem_wdata  output  32  assembled instruction word.
REQ-011 Port write_done  output  1  load complete, sticky until reset.
REQ-012 Port overflow  output  1  load ended by memory full, not by sentinel; sticky.
REQ-013 Port cpu_resetn  output  1  active-low core reset, low while loading.
REQ-014 Port word_count  output  ADDR_W+1  number of words written so far.

Function
REQ-015 The block SHALL assemble bytes little-endian: 1st byte -> [7:0], 2nd -> [15:8], 3rd -> [23:16], 4th -> [31:24].
REQ-016 A byte SHALL be accepted only when uart_rx_valid=1, uart_rx_break=0, write_done=0.
REQ-017 Byte index SHALL be a 2-bit counter 0..3, wrapping 3->0 on the 4th accepted byte.
REQ-018 States: LOAD (accepting), WRITE (one cycle), DONE (terminal until reset).
REQ-019 LOAD->WRITE on 4th byte accepted in cycle N, unless word = 0xFFFFFFFF; imem_we=1 in cycle N+1 with imem_addr = current address and imem_wdata = word.
REQ-020 WRITE->LOAD after one cycle; address and word_count SHALL increment by 1 on that edge.
REQ-021 A byte arriving during WRITE SHALL be accepted as byte 0 of the next word, no loss.
REQ-022 Assembled word 0xFFFFFFFF SHALL be a sentinel: not written, LOAD->DONE, write_done=1 from cycle N+1.
REQ-023 Write to address 2^ADDR_W-1 SHALL go WRITE->DONE with write_done=1 and overflow=1; address does not wrap.
REQ-024 In DONE all bytes, including further sentinels, SHALL be ignored; imem_we stays 0.
REQ-025 cpu_resetn SHALL equal write_done (core held in reset until load complete).
REQ-026 uart_rx_break=1 in LOAD SHALL clear byte index and partial word; a simultaneous uart_rx_valid byte is discarded (break wins).
REQ-027 imem_addr and imem_wdata SHALL hold their last values when imem_we=0.

Reset
REQ-028 resetn low SHALL asynchronously force: state LOAD, byte index 0, address 0, word_count 0, partial word 0, imem_we 0, imem_addr 0, imem_wdata 0, write_done 0, overflow 0, cpu_resetn 0.
REQ-029 Reset mid-word or mid-WRITE SHALL abort with no imem_we pulse; next load restarts at address 0.
REQ-030 Reset release SHALL be synchronous-deassert safe: first byte accepted no earlier than the 2nd clk edge after resetn rises.

Configuration
REQ-031 Macro LOADER_BYTE_TIMEOUT_EN defined: a cycle counter runs while byte index != 0 in LOAD, clears on each accepted byte; on reaching TIMEOUT_CYCLES it clears byte index and partial word.
REQ-032 Macro LOADER_BYTE_TIMEOUT_EN undefined: no counter; a partial word waits indefinitely for remaining bytes.

Verification
REQ-033 Bytes 13,01,01,FD -> one imem_we, addr 0, wdata 0xFD010113, word_count 1.
REQ-034 Words 0x00000000, 0x00000000, 0xFD010113, then FF x4, then FF x4 -> writes at addr 0,1,2 only; write_done=1, cpu_resetn=1, overflow=0, word_count 3; second sentinel ignored.
REQ-035 Bytes 23,26 then break pulse then 23,26,81,02 -> single write wdata 0x02812623 at addr 0.
REQ-036 ADDR_W=2, five words 0x00000001..0x00000005 -> writes addr 0..3, write_done=1, overflow=1, 5th word ignored.
REQ-037 resetn low between 2nd and 3rd byte -> no imem_we; after release, 4 bytes 93,07,30,FF -> wdata 0xFF300793 at addr 0.
REQ-038 LOADER_BYTE_TIMEOUT_EN, TIMEOUT_CYCLES=100: byte 6F, idle 150 cycles, then 6F,00,00,01 -> wdata 0x0100006F at addr 0.
